// File: rtl/sparse_mult_pkg.sv
// Shared types and constants for the sparse multiplier sequencer.
// Optional feature macro used by the sequencer: SPARSE_SCHED_DUMMY_EN.
package sparse_mult_pkg;

   localparam int unsigned RAMWIDTH  = 32;
   localparam int unsigned LOG_RW    = $clog2(RAMWIDTH);

   // Widest source/destination indices a job record can carry.
   localparam int unsigned JOB_SRC_W = 16;
   localparam int unsigned JOB_DST_W = 32;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FETCH = 3'd1,
      LATCH = 3'd2,
      RUN   = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef struct packed {
      logic [JOB_SRC_W-1:0] src;
      logic [JOB_DST_W-1:0] dst;
      logic [LOG_RW-1:0]    bit_off;
      logic                 dummy;
      logic                 last;
   } job_t;

endpackage

// File: rtl/sparse_mult_sched_if.sv
// Job stream between the sequencer and the shift-XOR accumulator.
// Handshake: a job transfers on a cycle where job_valid and job_ready are both 1;
// while job_valid=1 and job_ready=0 every job field holds stable, and job_valid
// never drops until the transfer happens.
interface sparse_mult_sched_if
   import sparse_mult_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LOGW       = 16
);
   localparam int unsigned DST_W = ADDR_WIDTH + LOGW - LOG_RW;

   logic                  job_valid;
   logic                  job_ready;
   logic [ADDR_WIDTH-1:0] src_addr;
   logic [DST_W-1:0]      dst_word;
   logic [LOG_RW-1:0]     bit_off;
   logic                  dummy;
   logic                  last;

   modport master (
      output job_valid, src_addr, dst_word, bit_off, dummy, last,
      input  job_ready
   );

   modport slave (
      input  job_valid, src_addr, dst_word, bit_off, dummy, last,
      output job_ready
   );

endinterface

// File: rtl/sparse_job_gen.sv
// Registered job-address arithmetic: source word, destination word and bit shift
// for one (position, word index) pair; results appear one cycle after the inputs.
module sparse_job_gen
   import sparse_mult_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned LOGW       = 16,
   parameter int unsigned DST_W      = ADDR_WIDTH + LOGW - LOG_RW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [LOGW-1:0]       pos_i,
   input  logic [ADDR_WIDTH-1:0] j_i,
   output logic [ADDR_WIDTH-1:0] src_o,
   output logic [DST_W-1:0]      dst_o,
   output logic [LOG_RW-1:0]     bit_off_o
);

   logic [ADDR_WIDTH-1:0] src_q;
   logic [DST_W-1:0]      dst_q;
   logic [LOG_RW-1:0]     bit_q;

   // Full-width add: modular reduction belongs to the accumulator.
   always_ff @(posedge clk) begin
      if (rst) begin
         src_q <= '0;
         dst_q <= '0;
         bit_q <= '0;
      end else begin
         src_q <= j_i;
         dst_q <= DST_W'(j_i) + DST_W'(pos_i[LOGW-1:LOG_RW]);
         bit_q <= pos_i[LOG_RW-1:0];
      end
   end

   assign src_o     = src_q;
   assign dst_o     = dst_q;
   assign bit_off_o = bit_q;

endmodule

// File: rtl/sparse_mult_sched.sv
// Sequencer walking every sparse position against every dense word, emitting accumulator jobs.
// Macro SPARSE_SCHED_DUMMY_EN pads to MAX_WEIGHT iterations with dummy jobs; undefined runs WEIGHT only.
module sparse_mult_sched
   import sparse_mult_pkg::*;
#(
   parameter int unsigned MAX_WEIGHT     = 75,
   parameter int unsigned WEIGHT         = 66,
   parameter int unsigned N              = 17669,
   parameter int unsigned Y              = 553,
   parameter int unsigned LOGW           = 16,
   parameter int unsigned LOG_MAX_WEIGHT = $clog2(MAX_WEIGHT),
   parameter int unsigned ADDR_WIDTH     = $clog2(Y)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start_i,
   output logic [LOG_MAX_WEIGHT-1:0] pos_addr_o,
   input  logic [LOGW-1:0]           pos_data_i,
   sparse_mult_sched_if.master       job,
   output logic                      busy_o,
   output logic                      done_o,
   output logic                      err_o,
   output state_t                    dbg_state_o
);

   localparam int unsigned DST_W = ADDR_WIDTH + LOGW - LOG_RW;
`ifdef SPARSE_SCHED_DUMMY_EN
   localparam int unsigned ITERS = MAX_WEIGHT;
`else
   localparam int unsigned ITERS = WEIGHT;
`endif
   localparam logic [LOG_MAX_WEIGHT-1:0] K_LAST = LOG_MAX_WEIGHT'(ITERS - 1);
   localparam logic [ADDR_WIDTH-1:0]     J_LAST = ADDR_WIDTH'(Y - 1);

   state_t                    state_q, state_d;
   logic [LOG_MAX_WEIGHT-1:0] k_q, k_d;
   logic [ADDR_WIDTH-1:0]     j_q, j_d;
   logic [LOGW-1:0]           pos_q, pos_d;
   logic                      err_q, err_d;
   logic                      bad_pos;
   logic                      run;
`ifdef SPARSE_SCHED_DUMMY_EN
   logic                      dummy_q, dummy_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         k_q     <= '0;
         j_q     <= '0;
         pos_q   <= '0;
         err_q   <= 1'b0;
`ifdef SPARSE_SCHED_DUMMY_EN
         dummy_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         j_q     <= j_d;
         pos_q   <= pos_d;
         err_q   <= err_d;
`ifdef SPARSE_SCHED_DUMMY_EN
         dummy_q <= dummy_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      k_d        = k_q;
      j_d        = j_q;
      pos_d      = pos_q;
      err_d      = err_q;
      bad_pos    = 1'b0;
      pos_addr_o = '0;
`ifdef SPARSE_SCHED_DUMMY_EN
      dummy_d    = dummy_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               err_d   = 1'b0;
               k_d     = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            // Dummy iterations still read address 0 so the access pattern hides WEIGHT.
            if (32'(k_q) < WEIGHT) pos_addr_o = k_q;
            state_d = LATCH;
         end
         LATCH: begin
            pos_d = pos_data_i;
            j_d   = '0;
`ifdef SPARSE_SCHED_DUMMY_EN
            dummy_d = (32'(k_q) >= WEIGHT);
            bad_pos = !dummy_d && (32'(pos_data_i) >= N);
            if (bad_pos) begin
               err_d   = 1'b1;
               dummy_d = 1'b1;
            end
            state_d = RUN;
`else
            bad_pos = (32'(pos_data_i) >= N);
            if (bad_pos) begin
               err_d = 1'b1;
               if (k_q == K_LAST) begin
                  state_d = DONE;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = FETCH;
               end
            end else begin
               state_d = RUN;
            end
`endif
         end
         RUN: begin
            if (job.job_ready) begin
               if (j_q == J_LAST) begin
                  if (k_q == K_LAST) begin
                     state_d = DONE;
                  end else begin
                     k_d     = k_q + 1'b1;
                     state_d = FETCH;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Fed with next-state values so the registered job lines up with j_q/pos_q.
   sparse_job_gen #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .LOGW       (LOGW),
      .DST_W      (DST_W)
   ) u_job_gen (
      .clk       (clk),
      .rst       (rst),
      .pos_i     (pos_d),
      .j_i       (j_d),
      .src_o     (job.src_addr),
      .dst_o     (job.dst_word),
      .bit_off_o (job.bit_off)
   );

   assign run           = (state_q == RUN);
   assign job.job_valid = run;
   assign job.last      = run && (j_q == J_LAST) && (k_q == K_LAST);
`ifdef SPARSE_SCHED_DUMMY_EN
   assign job.dummy     = run && dummy_q;
`else
   assign job.dummy     = 1'b0;
`endif

   assign busy_o      = (state_q == FETCH) || (state_q == LATCH) || run;
   assign done_o      = (state_q == DONE);
   assign err_o       = err_q;
   assign dbg_state_o = state_q;

endmodule
